// File: rtl/debounce_bank.sv
// Multi-channel push-button debouncer on a single clock with a shared sample-tick divider.
// Optional auto-repeat pulses are built when DEBOUNCE_BANK_REPEAT_EN is defined.

module debounce_bank_lane #(
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 300,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic button_i,
  output logic state_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  logic [1:0]       sync_q;
  logic [DEPTH-1:0] sh_q, sh_d;
  logic             state_q, state_d;
  logic             rise_q, fall_q;

  always_comb begin
    sh_d    = sh_q;
    state_d = state_q;
    if (tick_i) begin
      sh_d = {sh_q[DEPTH-2:0], sync_q[1]};
      if (&sh_d)       state_d = 1'b1;
      else if (~|sh_d) state_d = 1'b0;
    end
  end

  // Edge pulses are registered with the state so they line up with its first visible cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      sh_q    <= '0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_i};
      sh_q    <= sh_d;
      state_q <= state_d;
      rise_q  <= state_d & ~state_q;
      fall_q  <= ~state_d & state_q;
    end
  end

  assign state_o = state_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef DEBOUNCE_BANK_REPEAT_EN
  localparam int RCW    = $clog2(REPEAT_DELAY + 1);
  localparam int RELOAD = (REPEAT_PERIOD >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_PERIOD;
  localparam logic [RCW:0]   DELAY_W  = (RCW + 1)'(REPEAT_DELAY);
  localparam logic [RCW-1:0] RELOAD_W = RCW'(RELOAD);

  logic [RCW-1:0] rc_q, rc_d;
  logic [RCW:0]   rc_inc;
  logic           rep_q, rep_d;

  // A release on the same tick the delay expires wins: state_d low clears rc with no pulse.
  always_comb begin
    rc_d   = rc_q;
    rep_d  = 1'b0;
    rc_inc = {1'b0, rc_q} + 1'b1;
    if (!state_d || !state_q) begin
      rc_d = '0;
    end else if (tick_i) begin
      if (rc_inc == DELAY_W) begin
        rep_d = 1'b1;
        rc_d  = RELOAD_W;
      end else begin
        rc_d  = rc_inc[RCW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rc_q  <= '0;
      rep_q <= 1'b0;
    end else begin
      rc_q  <= rc_d;
      rep_q <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign repeat_o          = 1'b0;
`endif

endmodule

module debounce_bank #(
  parameter int N             = 4,
  parameter int TICK_DIV      = 100000,
  parameter int DEPTH         = 8,
  parameter int REPEAT_DELAY  = 300,
  parameter int REPEAT_PERIOD = 50
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] button_i,
  output logic [N-1:0] state_o,
  output logic [N-1:0] rise_o,
  output logic [N-1:0] fall_o,
  output logic [N-1:0] repeat_o
);

  localparam int DW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) div_q <= '0;
    else       div_q <= div_d;
  end

  debounce_bank_lane #(
    .DEPTH         (DEPTH),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_lane [N-1:0] (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_i   (tick),
    .button_i (button_i),
    .state_o  (state_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .repeat_o (repeat_o)
  );

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank with N=2, TICK_DIV=4, DEPTH=4, REPEAT_DELAY=3, REPEAT_PERIOD=2.
// Expects the repeat feature when DEBOUNCE_BANK_REPEAT_EN is defined, constant-zero repeat otherwise.

module tb_debounce_bank;

  logic       clk;
  logic       rst;
  logic [1:0] button;
  logic [1:0] state, rise, fall, rpt;

  int tests = 0;
  int fails = 0;

  debounce_bank #(
    .N(2), .TICK_DIV(4), .DEPTH(4), .REPEAT_DELAY(3), .REPEAT_PERIOD(2)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .button_i (button),
    .state_o  (state),
    .rise_o   (rise),
    .fall_o   (fall),
    .repeat_o (rpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic [1:0] btn, input int cycles);
    rst    = 1'b1;
    button = btn;
    for (int c = 0; c < cycles; c++) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int  lat;
    bit  found;
    logic seen_rise;
    rst = 1'b1; button = 2'b11;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({state, rise, fall, rpt} !== 8'h00) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %h want 00", c, {state, rise, fall, rpt});
      end
    end
    rst = 1'b0;
    found = 0; lat = 0; seen_rise = 1'b0;
    for (int c = 1; c <= 25 && !found; c++) begin
      step();
      if (state[0]) begin found = 1; lat = c; seen_rise = rise[0]; end
    end
    tests++;
    if (!found || lat < 15 || lat > 19) begin
      fails++;
      $display("FAIL reset_rise_latency: got %0d (found=%0d) want 15..19", lat, found);
    end
    tests++;
    if (seen_rise !== 1'b1) begin
      fails++;
      $display("FAIL reset_rise_pulse: got %b want 1", seen_rise);
    end
    step();
    tests++;
    if (rise[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_rise_width: got %b want 0", rise[0]);
    end
  endtask

  task automatic test_bounce();
    apply_reset(2'b00, 2);
    for (int c = 0; c < 200; c++) begin
      button[0] = ((c / 5) % 2) == 1;
      step();
      tests++;
      if ({state[0], rise[0], fall[0], rpt[0]} !== 4'b0000) begin
        fails++;
        $display("FAIL bounce_reject cycle %0d: got state/rise/fall/rep=%b want 0000", c,
                 {state[0], rise[0], fall[0], rpt[0]});
      end
    end
    button = 2'b00;
  endtask

  task automatic test_clean_ch1();
    int rcnt = 0, fcnt = 0, rlat = -1, flat = -1, ch0 = 0, both = 0;
    apply_reset(2'b00, 2);
    for (int c = 0; c < 3; c++) step();
    button[1] = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      step();
      if (rise[1]) begin rcnt++; if (rlat < 0) rlat = c; end
      if (fall[1]) begin fcnt++; if (flat < 0) flat = c - 40; end
      if (state[0] | rise[0] | fall[0]) ch0++;
      if ((rise & fall) != 2'b00) both++;
      if (c == 40) button[1] = 1'b0;
    end
    tests++;
    if (rcnt != 1) begin fails++; $display("FAIL ch1_rise_count: got %0d want 1", rcnt); end
    tests++;
    if (fcnt != 1) begin fails++; $display("FAIL ch1_fall_count: got %0d want 1", fcnt); end
    tests++;
    if (rlat < 15 || rlat > 19) begin fails++; $display("FAIL ch1_rise_latency: got %0d want 15..19", rlat); end
    tests++;
    if (flat < 15 || flat > 19) begin fails++; $display("FAIL ch1_fall_latency: got %0d want 15..19", flat); end
    tests++;
    if (ch0 != 0) begin fails++; $display("FAIL ch1_ch0_quiet: got %0d active cycles want 0", ch0); end
    tests++;
    if (both != 0) begin fails++; $display("FAIL ch1_rise_fall_overlap: got %0d want 0", both); end
    tests++;
    if (state !== 2'b00) begin fails++; $display("FAIL ch1_final_state: got %b want 00", state); end
  endtask

  task automatic test_simultaneous();
    bit found;
    apply_reset(2'b00, 2);
    button = 2'b11;
    found = 0;
    for (int c = 0; c < 25 && !found; c++) begin
      step();
      if (rise != 2'b00) found = 1;
    end
    tests++;
    if (!found || rise !== 2'b11) begin
      fails++;
      $display("FAIL simul_rise: got %b (found=%0d) want 11", rise, found);
    end
    step();
    tests++;
    if (rise !== 2'b00) begin fails++; $display("FAIL simul_rise_width: got %b want 00", rise); end
    button = 2'b10;
    found = 0;
    for (int c = 0; c < 25 && !found; c++) begin
      step();
      if (fall != 2'b00) found = 1;
    end
    tests++;
    if (!found || fall !== 2'b01) begin
      fails++;
      $display("FAIL simul_fall: got %b (found=%0d) want 01", fall, found);
    end
    tests++;
    if (state !== 2'b10 || rise !== 2'b00) begin
      fails++;
      $display("FAIL simul_after_fall: got state=%b rise=%b want state=10 rise=00", state, rise);
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    int lat;
    apply_reset(2'b00, 2);
    button = 2'b01;
    found = 0;
    for (int c = 0; c < 25 && !found; c++) begin
      step();
      if (state[0]) found = 1;
    end
    tests++;
    if (!found) begin fails++; $display("FAIL midrst_prequal: got state0=%b want 1", state[0]); end
    step(); step();
    rst = 1'b1;
    step();
    tests++;
    if ({state[0], rise[0], fall[0]} !== 3'b000) begin
      fails++;
      $display("FAIL midrst_clear: got state/rise/fall=%b want 000", {state[0], rise[0], fall[0]});
    end
    rst = 1'b0;
    found = 0; lat = 0;
    for (int c = 1; c <= 25 && !found; c++) begin
      step();
      if (rise[0]) begin found = 1; lat = c; end
    end
    tests++;
    if (!found || lat > 19) begin
      fails++;
      $display("FAIL midrst_rerise: got latency %0d (found=%0d) want <=19", lat, found);
    end
    button = 2'b00;
  endtask

  task automatic test_repeat();
    int rise_at = -1, fall_at = -1, cnt = 0, first = -1, last = -1, badint = 0, after = 0, ch1 = 0;
    apply_reset(2'b01, 2);
    for (int c = 1; c <= 140; c++) begin
      step();
      if (rise[0] && rise_at < 0) rise_at = c;
      if (fall[0] && fall_at < 0) fall_at = c;
      if (rpt[1]) ch1++;
      if (rpt[0]) begin
        if (fall_at >= 0) after++;
        if (last >= 0 && c - last != 8) badint++;
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (c == 100) button[0] = 1'b0;
    end
    tests++;
    if (rise_at != 16) begin fails++; $display("FAIL rep_rise_time: got %0d want 16", rise_at); end
    tests++;
    if (fall_at != 116) begin fails++; $display("FAIL rep_fall_time: got %0d want 116", fall_at); end
    tests++;
    if (ch1 != 0) begin fails++; $display("FAIL rep_ch1_quiet: got %0d want 0", ch1); end
`ifdef DEBOUNCE_BANK_REPEAT_EN
    tests++;
    if (first != 28) begin fails++; $display("FAIL rep_first: got %0d want 28", first); end
    tests++;
    if (badint != 0) begin fails++; $display("FAIL rep_period: got %0d bad intervals want 0", badint); end
    tests++;
    if (cnt != 11 || last != 108) begin
      fails++;
      $display("FAIL rep_count: got %0d pulses last=%0d want 11 last=108", cnt, last);
    end
    tests++;
    if (after != 0) begin fails++; $display("FAIL rep_after_fall: got %0d want 0", after); end
`else
    tests++;
    if (cnt != 0) begin fails++; $display("FAIL rep_disabled: got %0d pulses want 0", cnt); end
`endif
    button = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    button = 2'b00;
    test_reset();
    test_bounce();
    test_clean_ch1();
    test_simultaneous();
    test_mid_reset();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel push-button debouncer for the pong input path, replacing the single-channel, derived-clock debouncer. All channels run on the system clock, gated by one internal sample-tick divider, so the block has no generated clocks. Each channel has a 2-flop synchroniser, a DEPTH-sample shift-register filter, a stable level output and one-cycle rise/fall event pulses. An optional auto-repeat feature gives held paddle buttons periodic move pulses.

## Interface
- `N`, 4: number of independent button channels (≥1).
- `TICK_DIV`, 100000: clk cycles per sample tick (≥2); 1 ms at 100 MHz.
- `DEPTH`, 8: consecutive equal samples required to change state (≥2).
- `REPEAT_DELAY`, 300: ticks from debounced press to first repeat pulse (≥1); used only with the macro.
- `REPEAT_PERIOD`, 50: ticks between subsequent repeat pulses (≥1); used only with the macro.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `button`  in  N  raw, asynchronous, bouncing button levels, active-high.
- `state`  out  N  debounced level per channel.
- `rise`  out  N  one-clk pulse when `state[i]` goes 0→1.
- `fall`  out  N  one-clk pulse when `state[i]` goes 1→0.
- `repeat`  out  N  one-clk auto-repeat pulse; constant 0 when the feature is compiled out.

## Operation
- Synchroniser: `button[i]` passes through two flops to give `sync[i]`. There is no other use of raw inputs.
- Tick divider: shared counter `div`, width `$clog2(TICK_DIV)`. It counts 0..TICK_DIV-1 and wraps to 0. `tick` is high in the single cycle where `div == TICK_DIV-1`.
- Filter: on a tick cycle, each channel updates `sh_next = {sh[DEPTH-2:0], sync[i]}`.
  - `sh_next` all ones: `state[i]` becomes 1.
  - `sh_next` all zeros: `state[i]` becomes 0.
  - Otherwise `state[i]` holds.
  - `sh` and `state` update on the same edge.
- Events: `rise[i]` and `fall[i]` are registered alongside `state[i]` from the new versus old state. Each is high for exactly the one cycle in which the new `state[i]` is first visible. `rise[i]` and `fall[i]` are never both high.
- Channels are fully independent; any mix of channels may change on the same tick.
- Repeat, when enabled: per-channel tick counter `rc`.
  - Cleared to 0 on the edge where `state[i]` rises.
  - While `state[i]==1`, it increments on each tick.
  - When it reaches REPEAT_DELAY, `repeat[i]` pulses for 1 clk and `rc` reloads to REPEAT_DELAY-REPEAT_PERIOD, so subsequent pulses fall every REPEAT_PERIOD ticks.
  - While `state[i]==0`, `rc` is held at 0 and `repeat[i]` stays 0.
  - The press itself produces `rise`, not `repeat`.
- Reset, including mid-bounce or mid-repeat:
  - Synchroniser, `div`, all `sh`, `state`, `rise`, `fall`, `repeat` and `rc` go to 0 on the next edge.
  - A button held through reset is re-qualified from scratch and produces a fresh `rise`.

## Timing
- Reset values: `state`, `rise`, `fall` and `repeat` are all 0. `div` is 0, so the first tick occurs in cycle TICK_DIV-1 after reset release.
- Press latency, counted from an input held stable from cycle t until `state` is seen high:
  - Minimum: 2 + (DEPTH-1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + DEPTH·TICK_DIV + 1 cycles.
  - Release latency is the same.
- A glitch of any length shorter than DEPTH consecutive ticks never changes `state`.
- Output pulses are exactly 1 clk wide and coincide with a tick cycle plus one edge.
- Repeat: the first `repeat[i]` comes REPEAT_DELAY ticks after `rise[i]`, then one every REPEAT_PERIOD ticks.
- If `state` falls on the same tick that `rc` reaches REPEAT_DELAY, `fall` is emitted and `repeat` is suppressed.

## Configuration
- Macro: `DEBOUNCE_BANK_REPEAT_EN`.
- Defined: the `rc` counters and the repeat logic are synthesised. REPEAT_DELAY and REPEAT_PERIOD are active.
- Undefined: no `rc` registers are built. `repeat` is tied to N'b0. REPEAT_* parameters are ignored. All other behaviour is identical.

## Test plan
Parameters: N=2, TICK_DIV=4, DEPTH=4; where used, REPEAT_DELAY=3, REPEAT_PERIOD=2.
- Reset: hold `rst` for 3 cycles with `button`=2'b11 → all outputs 0 during reset. Then `state[0]` goes to 1, with a one-cycle `rise[0]`, between cycles 15 and 19 after release.
- Bounce rejection: toggle `button[0]` every 5 cycles for 200 cycles → `state[0]`, `rise[0]` and `fall[0]` stay 0 throughout.
- Clean press/release on ch1: high for 40 cycles, then low → exactly one `rise[1]` and one `fall[1]`, each 1 clk wide. Channel 0 is unaffected. Latencies fall within 15–19 cycles.
- Simultaneous: both channels rise in the same cycle → `rise` = 2'b11 for one cycle. Later `button[0]` falls while `button[1]` stays high → only `fall[0]`.
- Mid-operation reset: assert `rst` for 1 cycle while `state[0]`=1 → `state[0]`=0 next cycle with no `fall` pulse. The still-held button then yields a new `rise[0]` within 19 cycles.
- Repeat (macro defined): hold `button[0]` 100 cycles → first `repeat[0]` 3 ticks (12 clk) after `rise[0]`, then every 8 clk. No `repeat` after `fall[0]`.
- Repeat (macro undefined): the same stimulus → `repeat` constantly 0.
